// File: rtl/compare_probe_search_pkg.sv
// Shared definitions for the magnitude-compare interface: one-hot relation codes and the
// initiator FSM state encoding. Comparator responders use the same codes.
package compare_probe_search_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;  // target > probe
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;  // target < probe

  typedef enum logic [1:0] {
    StIdle,
    StProbe,
    StDone
  } state_e;

endpackage

// File: rtl/cmp_rsp_check.sv
// Combinational decode of a responder relation code, plus detection of answers that are
// inconsistent with the current search range.
module cmp_rsp_check
  import compare_probe_search_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [2:0] rsp,
  input  logic [W:0] probe,
  input  logic [W:0] lo,
  input  logic [W:0] hi,
  output logic       is_gt,
  output logic       is_eq,
  output logic       is_lt,
  output logic       bad,
  output logic       gt_at_hi,
  output logic       lt_at_lo
);

  assign is_gt = (rsp == CMP_GT);
  assign is_eq = (rsp == CMP_EQ);
  assign is_lt = (rsp == CMP_LT);
  // Anything but exactly one of the three codes (000 or multi-hot).
  assign bad   = !(is_gt || is_eq || is_lt);

  // Target cannot lie above hi or below lo; such answers would collapse the range.
  assign gt_at_hi = is_gt && (probe == hi);
  assign lt_at_lo = is_lt && (probe == lo);

endmodule

// File: rtl/compare_probe_search.sv
// Binary-search initiator: probes a comparator responder until it answers EQ, reporting the
// found value, the number of probes and any protocol error or response timeout.
module compare_probe_search
  import compare_probe_search_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic [W-1:0]             probe,
  output logic                     probe_valid,
  input  logic                     rsp_valid,
  input  logic [2:0]               rsp,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic                     error,
  output logic [W-1:0]             result,
  output logic [$clog2(W+2)-1:0]   probe_cnt
);

  localparam int unsigned CW = $clog2(W + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [W:0] HiInit = {1'b0, {W{1'b1}}};

  state_e        state_q, state_d;
  logic [W:0]    lo_q, lo_d, hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found_q, found_d, error_q, error_d;
  logic [W-1:0]  result_q, result_d;

  logic [W:0] mid;
  logic       is_gt, is_eq, is_lt, bad, gt_at_hi, lt_at_lo;

  // lo/hi carry an extra bit so mid+1 and mid-1 never wrap at the range ends.
  assign mid = lo_q + ((hi_q - lo_q) >> 1);

  cmp_rsp_check #(
    .W(W)
  ) u_rsp_check (
    .rsp      (rsp),
    .probe    (mid),
    .lo       (lo_q),
    .hi       (hi_q),
    .is_gt    (is_gt),
    .is_eq    (is_eq),
    .is_lt    (is_lt),
    .bad      (bad),
    .gt_at_hi (gt_at_hi),
    .lt_at_lo (lt_at_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    error_d  = error_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d  = StProbe;
          lo_d     = '0;
          hi_d     = HiInit;
          tmo_d    = '0;
          cnt_d    = '0;
          found_d  = 1'b0;
          error_d  = 1'b0;
          result_d = '0;
        end
      end
      StProbe: begin
        if (abort) begin
          // Abort wins over a coincident response; the answer is dropped.
          state_d = StIdle;
        end else if (rsp_valid) begin
          cnt_d = cnt_q + CW'(1);
          tmo_d = '0;
          if (bad || gt_at_hi || lt_at_lo) begin
            error_d = 1'b1;
            found_d = 1'b0;
            state_d = StDone;
          end else if (is_eq) begin
            result_d = mid[W-1:0];
            found_d  = 1'b1;
            state_d  = StDone;
          end else if (is_gt) begin
            lo_d = mid + (W + 1)'(1);
          end else if (is_lt) begin
            hi_d = mid - (W + 1)'(1);
          end
        end else if (tmo_q == TmoLast) begin
          error_d = 1'b1;
          found_d = 1'b0;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q == StProbe);
  assign probe_valid = busy;
  assign probe       = busy ? mid[W-1:0] : '0;
  assign done        = (state_q == StDone);
  assign found       = found_q;
  assign error       = error_q;
  assign result      = result_q;
  assign probe_cnt   = cnt_q;

endmodule

// File: tb/tb_compare_probe_search.sv
// Bench for compare_probe_search with W=4: a comparator responder over a fixed target (or a
// forced faulty code), expected outcomes queued at start and checked when done pulses.
module tb_compare_probe_search;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, rsp_valid, rsp_en;
  logic [3:0] probe, result, target;
  logic       probe_valid, busy, done, found, error;
  logic [2:0] rsp, probe_cnt;
  int         mode;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       found;
    logic       error;
    logic [3:0] result;
    logic [2:0] cnt;
    int         done_cyc;
    bit         chk_result;
  } exp_t;

  exp_t sb_q[$];
  int   exp_probes[$];

  always #5 clk = ~clk;

  compare_probe_search dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .probe       (probe),
    .probe_valid (probe_valid),
    .rsp_valid   (rsp_valid),
    .rsp         (rsp),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .error       (error),
    .result      (result),
    .probe_cnt   (probe_cnt)
  );

  // Responder: 0 = honest comparator, 1 = multi-hot 110, 2 = always GT.
  assign rsp_valid = probe_valid & rsp_en;
  always_comb begin
    rsp = 3'b000;
    if (mode == 1)           rsp = 3'b110;
    else if (mode == 2)      rsp = 3'b100;
    else if (target > probe) rsp = 3'b100;
    else if (target == probe) rsp = 3'b010;
    else                     rsp = 3'b001;
  end

  // Cycle numbering: start sampled at the edge ending cycle 0; probes from cycle 1.
  task automatic run_search(input logic [3:0] tgt, input int md, input int en_cyc,
                            input int restart_cyc, input logic e_found, input logic e_error,
                            input logic [3:0] e_result, input logic [2:0] e_cnt,
                            input int e_done, input bit chk_res);
    exp_t e;
    int   ep;
    int   cyc;
    bit   seen;
    e.found = e_found; e.error = e_error; e.result = e_result; e.cnt = e_cnt;
    e.done_cyc = e_done; e.chk_result = chk_res;
    sb_q.push_back(e);
    target = tgt; mode = md; rsp_en = (en_cyc == 0);
    seen = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (c == en_cyc) rsp_en = 1'b1;
      #1;
      if (probe_valid && rsp_valid) begin
        n_tests++;
        if (exp_probes.size() == 0) begin
          n_fail++;
          $display("FAIL probe_seq: got unexpected probe %0d, required none", probe);
        end else begin
          ep = exp_probes.pop_front();
          if (probe !== 4'(ep)) begin
            n_fail++;
            $display("FAIL probe_seq: got %0d required %0d (cycle %0d)", probe, ep, c);
          end
        end
      end
      if (done) begin
        seen = 1; cyc = c;
        break;
      end
    end
    start = 1'b0; rsp_en = 1'b0;
    e = sb_q.pop_front();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles (target %0d)", tgt);
    end else begin
      if (cyc !== e.done_cyc) begin
        n_fail++;
        $display("FAIL done_cycle: got %0d required %0d", cyc, e.done_cyc);
      end
      n_tests++;
      if (found !== e.found || error !== e.error) begin
        n_fail++;
        $display("FAIL flags: got found=%b error=%b required found=%b error=%b",
                 found, error, e.found, e.error);
      end
      n_tests++;
      if (probe_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL probe_cnt: got %0d required %0d", probe_cnt, e.cnt);
      end
      if (e.chk_result) begin
        n_tests++;
        if (result !== e.result) begin
          n_fail++;
          $display("FAIL result: got %0d required %0d", result, e.result);
        end
      end
    end
    n_tests++;
    if (exp_probes.size() != 0) begin
      n_fail++;
      $display("FAIL probes_missing: got %0d left over, required 0", exp_probes.size());
    end
    exp_probes.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || probe_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b pv=%b done=%b required 0 0 0",
               busy, probe_valid, done);
    end
    n_tests++;
    if ({probe, found, error, result, probe_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_data: got probe=%0d found=%b error=%b result=%0d cnt=%0d required 0",
               probe, found, error, result, probe_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_search();
    exp_probes = '{7, 11};
    run_search(4'd11, 0, 0, 0, 1'b1, 1'b0, 4'd11, 3'd2, 3, 1);
    exp_probes = '{7, 3, 1, 0};
    run_search(4'd0, 0, 0, 0, 1'b1, 1'b0, 4'd0, 3'd4, 5, 1);
    exp_probes = '{7, 11, 13, 14, 15};
    run_search(4'd15, 0, 0, 0, 1'b1, 1'b0, 4'd15, 3'd5, 6, 1);
  endtask

  task automatic test_errors();
    exp_probes = '{7};
    run_search(4'd0, 1, 0, 0, 1'b0, 1'b1, 4'd0, 3'd1, 2, 0);
    exp_probes = '{7, 11, 13, 14, 15};
    run_search(4'd0, 2, 0, 0, 1'b0, 1'b1, 4'd0, 3'd5, 6, 0);
  endtask

  task automatic test_timeout();
    // Silent responder: 16 probe cycles, then done.
    run_search(4'd11, 0, 99, 0, 1'b0, 1'b1, 4'd0, 3'd0, 17, 0);
    // Answer arrives after 15 silent cycles: no timeout.
    exp_probes = '{7, 11};
    run_search(4'd11, 0, 16, 0, 1'b1, 1'b0, 4'd11, 3'd2, 18, 1);
  endtask

  task automatic test_start_busy();
    // A second start mid-search must not restart the search or its timeout.
    run_search(4'd3, 0, 99, 3, 1'b0, 1'b1, 4'd0, 3'd0, 17, 0);
  endtask

  task automatic test_abort();
    int dones;
    target = 4'd11; mode = 0; rsp_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || probe_valid !== 1'b0 || probe_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b pv=%b cnt=%0d required 0 0 1",
               busy, probe_valid, probe_cnt);
    end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      @(negedge clk); #1;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", dones);
    end
    rsp_en = 1'b0;
    exp_probes = '{7, 3, 5};
    run_search(4'd5, 0, 0, 0, 1'b1, 1'b0, 4'd5, 3'd3, 4, 1);
  endtask

  task automatic test_reset_mid();
    target = 4'd15; mode = 0; rsp_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rsp_en = 1'b0;
    #1;
    n_tests++;
    if ({probe, probe_valid, busy, done, found, error, result, probe_cnt} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got probe=%0d pv=%b busy=%b done=%b cnt=%0d required all 0",
               probe, probe_valid, busy, done, probe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    target = 4'd11; mode = 0; rsp_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (done) seen = 1;
      else @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    n_tests++;
    if (!seen || probe_valid !== 1'b1 || probe !== 4'd7) begin
      n_fail++;
      $display("FAIL back_to_back: got seen=%b pv=%b probe=%0d required 1 1 7",
               seen, probe_valid, probe);
    end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    n_tests++;
    if (!seen || found !== 1'b1 || result !== 4'd11) begin
      n_fail++;
      $display("FAIL back_to_back_result: got seen=%b found=%b result=%0d required 1 1 11",
               seen, found, result);
    end
    rsp_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rsp_en = 1'b0; mode = 0; target = 4'd0;
    test_reset();
    test_search();
    test_errors();
    test_timeout();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
